// File: rtl/ext_arbiter.sv
// Two-requester round-robin front end for a single shared immediate extender.
// One transaction in flight at a time: accept in IDLE, sample the extender in EXEC, hand back in RESP.
module ext_arbiter #(
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [15:0]     r0_imm,
  input  logic [OP_W-1:0] r0_op,
  input  logic            r0_in,

  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [15:0]     r1_imm,
  input  logic [OP_W-1:0] r1_op,
  input  logic            r1_in,

  output logic [15:0]     ext_orig,
  output logic [OP_W-1:0] ext_op,
  output logic            ext_input,
  input  logic [31:0]     ext_result,

  output logic            r0_rsp_valid,
  input  logic            r0_rsp_ready,
  output logic            r1_rsp_valid,
  input  logic            r1_rsp_ready,
  output logic [31:0]     rsp_data
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic              gnt_q;
  logic              ptr_q;
  logic [15:0]       hold_imm_q;
  logic [OP_W-1:0]   hold_op_q;
  logic              hold_in_q;
  logic [31:0]       rsp_data_q;

  logic              any_valid;
  logic              winner;
  logic              rsp_ack;

  always_comb begin
    any_valid = r0_valid | r1_valid;
    // r1 wins when it is the only requester, or when both request and it holds the pointer
    winner    = r1_valid & (~r0_valid | ptr_q);
    rsp_ack   = gnt_q ? r1_rsp_ready : r0_rsp_ready;
    r0_ready  = (state_q == StIdle) & any_valid & ~winner;
    r1_ready  = (state_q == StIdle) & winner;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'b0;
      hold_imm_q <= '0;
      hold_op_q  <= '0;
      hold_in_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            hold_imm_q <= winner ? r1_imm : r0_imm;
            hold_op_q  <= winner ? r1_op  : r0_op;
            hold_in_q  <= winner ? r1_in  : r0_in;
            gnt_q      <= winner;
            state_q    <= StExec;
          end
        end
        StExec: begin
          rsp_data_q <= ext_result;
          state_q    <= StResp;
        end
        StResp: begin
          if (rsp_ack) begin
            ptr_q   <= ~gnt_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ext_orig     = hold_imm_q;
  assign ext_op       = hold_op_q;
  assign ext_input    = hold_in_q;
  assign rsp_data     = rsp_data_q;
  assign r0_rsp_valid = (state_q == StResp) & ~gnt_q;
  assign r1_rsp_valid = (state_q == StResp) & gnt_q;

endmodule
